// File: rtl/ciclo_lavadora.sv
// Washing-machine cycle sequencer: runs dry, wash or heavy-wash programs through timed phases.
// Optional pause input enabled with `define CICLO_LAVADORA_PAUSA_EN.
module ciclo_lavadora #(
   parameter int unsigned TW      = 16,
   parameter int unsigned T_FILL  = 4,
   parameter int unsigned T_WASH  = 8,
   parameter int unsigned T_RINSE = 4,
   parameter int unsigned T_SPIN  = 3,
   parameter int unsigned T_DRY   = 6,
   parameter int unsigned T_DOOR  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_secado,
   input  logic       req_lavado,
   input  logic       req_lavado_pesado,
`ifdef CICLO_LAVADORA_PAUSA_EN
   input  logic       pausa,
`endif
   input  logic       puerta_cerrada,
   output logic       valvula_agua,
   output logic       motor_on,
   output logic       calentador,
   output logic       centrifugado,
   output logic       bloqueo_puerta,
   output logic       ocupado,
   output logic       fin,
   output logic       abortado,
   output logic       error_puerta,
   output logic [2:0] fase
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StWaitDoor = 3'd1,
      StFill     = 3'd2,
      StWash     = 3'd3,
      StRinse    = 3'd4,
      StSpin     = 3'd5,
      StDry      = 3'd6,
      StDone     = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      ProgNone,
      ProgSecado,
      ProgLavado,
      ProgPesado
   } prog_e;

   state_e          state_q;
   prog_e           prog_q;
   logic [TW-1:0]   timer_q;
   logic            abort_q;

   prog_e           req_prog;
   logic            req_any;
   logic            active;
   logic            pause;
   logic            hold;

   function automatic state_e first_phase(input prog_e p);
      return (p == ProgSecado) ? StDry : StFill;
   endfunction

   function automatic state_e next_phase(input state_e s, input prog_e p);
      case (s)
         StFill:  return StWash;
         StWash:  return StRinse;
         StRinse: return StSpin;
         StSpin:  return (p == ProgPesado) ? StDry : StDone;
         default: return StDone;
      endcase
   endfunction

   // Timer load value is duration-1 so that a phase lasts exactly its duration.
   function automatic logic [TW-1:0] phase_load(input state_e s, input prog_e p);
      case (s)
         StFill:  return TW'(T_FILL - 1);
         StWash:  return (p == ProgPesado) ? TW'(2 * T_WASH - 1) : TW'(T_WASH - 1);
         StRinse: return TW'(T_RINSE - 1);
         StSpin:  return TW'(T_SPIN - 1);
         StDry:   return TW'(T_DRY - 1);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      req_prog = ProgNone;
      if (req_lavado_pesado)  req_prog = ProgPesado;
      else if (req_lavado)    req_prog = ProgLavado;
      else if (req_secado)    req_prog = ProgSecado;
   end

   assign req_any = (req_prog != ProgNone);
   assign active  = (state_q >= StFill) && (state_q <= StDry);

`ifdef CICLO_LAVADORA_PAUSA_EN
   assign pause = pausa;
`else
   assign pause = 1'b0;
`endif

   assign hold = active && (!puerta_cerrada || pause);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         prog_q  <= ProgNone;
         timer_q <= '0;
         abort_q <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_any) begin
                  prog_q <= req_prog;
                  if (puerta_cerrada) begin
                     state_q <= first_phase(req_prog);
                     timer_q <= phase_load(first_phase(req_prog), req_prog);
                  end else begin
                     state_q <= StWaitDoor;
                     timer_q <= TW'(T_DOOR - 1);
                  end
               end
            end
            StWaitDoor: begin
               // Door closing wins over a simultaneous timeout.
               if (puerta_cerrada) begin
                  state_q <= first_phase(prog_q);
                  timer_q <= phase_load(first_phase(prog_q), prog_q);
               end else if (timer_q == '0) begin
                  state_q <= StIdle;
                  prog_q  <= ProgNone;
                  abort_q <= 1'b1;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            StFill, StWash, StRinse, StSpin, StDry: begin
               if (!hold) begin
                  if (timer_q == '0) begin
                     state_q <= next_phase(state_q, prog_q);
                     timer_q <= phase_load(next_phase(state_q, prog_q), prog_q);
                  end else begin
                     timer_q <= timer_q - TW'(1);
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               prog_q  <= ProgNone;
               timer_q <= '0;
            end
         endcase
      end
   end

   assign valvula_agua   = !hold && ((state_q == StFill) || (state_q == StRinse));
   assign motor_on       = !hold && ((state_q == StWash) || (state_q == StRinse) ||
                                     (state_q == StSpin) || (state_q == StDry));
   assign calentador     = !hold && ((state_q == StDry) ||
                                     ((state_q == StWash) && (prog_q == ProgPesado)));
   assign centrifugado   = !hold && (state_q == StSpin);
   assign bloqueo_puerta = (state_q >= StFill);
   assign ocupado        = (state_q != StIdle);
   assign fin            = (state_q == StDone);
   assign abortado       = abort_q;
   assign error_puerta   = active && !puerta_cerrada;
   assign fase           = state_q;

endmodule
